// File: rtl/nvme_ucq_cq.sv
// Microcode completion queue: NVMe side pushes CQEs, microcontroller reads/pops them over the IO bus.
// Latency: pop/reset IO writes ack same cycle; IO reads ack 2 cycles after the strobe; push visible next cycle.
// Backpressure: cq_wrready drops when full, during init or on queue reset; a pop right after a pop stalls its ack 1 cycle.
module nvme_ucq_cq #(
    parameter int num_entries  = 4,
    parameter int cq_width     = 128,
    parameter int sq_ptr_width = 2,
    parameter int ioaddr_base  = 0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [31:0]                         ctl_cq_ioaddress,
    input  logic                                ctl_cq_ioread_strobe,
    input  logic [35:0]                         ctl_cq_iowrite_data,
    input  logic                                ctl_cq_iowrite_strobe,
    output logic [35:0]                         cq_ctl_ioread_data,
    output logic                                cq_ctl_ioack,
    input  logic                                cq_wrval,
    input  logic [cq_width+cq_width/8-1:0]      cq_wrdata,
    output logic                                cq_wrready,
    output logic [$clog2(num_entries)-1:0]      cq_head,
    output logic [$clog2(num_entries)-1:0]      cq_tail,
    output logic                                cq_doorbell,
    output logic                                sq_head_update,
    output logic [sq_ptr_width-1:0]             sq_head_new,
    input  logic                                q_reset,
    output logic                                cq_reset
);
    localparam int pw = $clog2(num_entries);
    localparam int ew = cq_width + cq_width / 8;
    localparam logic [4:0] sel_code = {4'(ioaddr_base), 1'b1};

    logic [ew-1:0] mem [num_entries];
    logic [ew-1:0] head_copy;
    logic [pw-1:0] head, tail;
    logic          phase;
    logic [pw:0]   init_cnt;
    logic          init_done, full, empty;
    logic          io_sel, wr_sel, pop_req, rst_req, pop_stall, do_pop, q_clr, push;
    logic [4:0]    off;
    logic          pop_q, rd_vld1, rd_ack_q;
    logic [4:0]    rd_off1;
    logic [35:0]   rd_mux;
    logic          unused_ok;

    assign init_done = init_cnt[pw];
    assign full      = (head == tail + 1'b1);
    assign empty     = (head == tail);

    assign io_sel    = (ctl_cq_ioaddress[11:7] == sel_code);
    assign off       = ctl_cq_ioaddress[6:2];
    assign wr_sel    = ctl_cq_iowrite_strobe & io_sel;
    assign pop_req   = wr_sel & (off == 5'h10);
    assign rst_req   = wr_sel & (off == 5'h1C);
    // the head copy is stale for one cycle after a pop, so a back-to-back pop waits
    assign pop_stall = pop_req & pop_q;
    assign do_pop    = pop_req & ~pop_q & ~empty & ~q_reset;
    assign q_clr     = rst_req | q_reset;

    assign cq_wrready     = reset_n & init_done & ~full & ~rst_req & ~q_reset;
    assign push           = cq_wrval & cq_wrready;
    assign cq_reset       = rst_req;
    assign cq_doorbell    = do_pop;
    assign sq_head_update = do_pop;
    assign sq_head_new    = do_pop ? head_copy[64 +: sq_ptr_width] : '0;
    assign cq_ctl_ioack   = (wr_sel & ~pop_stall) | rd_ack_q;
    assign cq_head        = head;
    assign cq_tail        = tail;

    assign unused_ok = ^{ctl_cq_iowrite_data, ctl_cq_ioaddress[31:12], ctl_cq_ioaddress[1:0]};

    always_comb begin
        rd_mux = {4'hF, 32'h0};
        if (rd_off1[4:2] == 3'b000) begin
            rd_mux = {head_copy[cq_width + {rd_off1[1:0], 2'b00} +: 4],
                      head_copy[{rd_off1[1:0], 5'b00000} +: 32]};
        end else if (rd_off1 == 5'h14) begin
            rd_mux = {3'b111, ~^{phase, full, empty}, 29'h0, phase, full, empty};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head               <= '0;
            tail               <= '0;
            phase              <= 1'b1;
            init_cnt           <= '0;
            pop_q              <= 1'b0;
            rd_vld1            <= 1'b0;
            rd_off1            <= '0;
            rd_ack_q           <= 1'b0;
            cq_ctl_ioread_data <= {4'hF, 32'h0};
        end else begin
            if (!init_done) begin
                init_cnt <= init_cnt + 1'b1;
            end
            pop_q <= do_pop;
            if (q_clr) begin
                head  <= '0;
                tail  <= '0;
                phase <= 1'b1;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                    if (tail == pw'(num_entries - 1)) begin
                        phase <= ~phase;
                    end
                end
                if (do_pop) begin
                    head <= head + 1'b1;
                end
            end
            rd_vld1  <= ctl_cq_ioread_strobe & io_sel;
            rd_off1  <= off;
            rd_ack_q <= rd_vld1;
            if (rd_vld1) begin
                cq_ctl_ioread_data <= rd_mux;
            end
        end
    end

    // storage and head-entry copy; a push into an empty queue bypasses straight into the copy
    always_ff @(posedge clk) begin
        if (!init_done) begin
            mem[init_cnt[pw-1:0]] <= {{(cq_width/8){1'b1}}, {cq_width{1'b0}}};
        end else if (push) begin
            mem[tail] <= cq_wrdata;
        end
        head_copy <= (push && (tail == head)) ? cq_wrdata : mem[head];
    end
endmodule

// File: tb/tb_nvme_ucq_cq.sv
// Bench for nvme_ucq_cq: directed table reads, hand corner sequences and a randomized run against a queue model.
module tb_nvme_ucq_cq;
    localparam int NE = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  ctl_cq_ioaddress;
    logic         ctl_cq_ioread_strobe;
    logic [35:0]  ctl_cq_iowrite_data;
    logic         ctl_cq_iowrite_strobe;
    logic [35:0]  cq_ctl_ioread_data;
    logic         cq_ctl_ioack;
    logic         cq_wrval;
    logic [143:0] cq_wrdata;
    logic         cq_wrready;
    logic [1:0]   cq_head, cq_tail;
    logic         cq_doorbell, sq_head_update;
    logic [1:0]   sq_head_new;
    logic         q_reset, cq_reset;

    always #5 clk = ~clk;

    nvme_ucq_cq dut (
        .clk(clk), .reset_n(reset_n),
        .ctl_cq_ioaddress(ctl_cq_ioaddress), .ctl_cq_ioread_strobe(ctl_cq_ioread_strobe),
        .ctl_cq_iowrite_data(ctl_cq_iowrite_data), .ctl_cq_iowrite_strobe(ctl_cq_iowrite_strobe),
        .cq_ctl_ioread_data(cq_ctl_ioread_data), .cq_ctl_ioack(cq_ctl_ioack),
        .cq_wrval(cq_wrval), .cq_wrdata(cq_wrdata), .cq_wrready(cq_wrready),
        .cq_head(cq_head), .cq_tail(cq_tail), .cq_doorbell(cq_doorbell),
        .sq_head_update(sq_head_update), .sq_head_new(sq_head_new),
        .q_reset(q_reset), .cq_reset(cq_reset)
    );

    int tests = 0;
    int fails = 0;

    // reference model: FIFO contents plus pointer indices as plain modular counters
    logic [143:0] mq[$];
    int           m_head, m_tail;
    logic         m_phase;
    logic         m_last_pop;

    typedef struct {
        logic [31:0] addr;
        logic [35:0] exp;
        string       nm;
    } rd_vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        ctl_cq_ioaddress      = 32'h0;
        ctl_cq_ioread_strobe  = 1'b0;
        ctl_cq_iowrite_data   = 36'h0;
        ctl_cq_iowrite_strobe = 1'b0;
        cq_wrval              = 1'b0;
        cq_wrdata             = '0;
        q_reset               = 1'b0;
    endtask

    function automatic logic [3:0] par4(input logic [31:0] d);
        logic [3:0] p;
        for (int b = 0; b < 4; b++) p[b] = ~^d[8*b +: 8];
        return p;
    endfunction

    function automatic logic [143:0] mk_entry(input logic [31:0] k);
        logic [31:0] d0, d1, d2, d3;
        d0 = 32'hA0A0_0000 | k;
        d1 = 32'hB1B1_0000 | k;
        d2 = k;
        d3 = 32'hC3C3_0000 | k;
        return {par4(d3), par4(d2), par4(d1), par4(d0), d3, d2, d1, d0};
    endfunction

    function automatic logic [143:0] rnd_entry();
        return {16'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [35:0] status_exp();
        logic ph, f, e;
        ph = m_phase;
        f  = (mq.size() == NE - 1);
        e  = (mq.size() == 0);
        return {3'b111, ~^{ph, f, e}, 29'h0, ph, f, e};
    endfunction

    function automatic logic [35:0] dw_exp(input logic [143:0] ent, input int k);
        return {ent[128 + 4*k +: 4], ent[32*k +: 32]};
    endfunction

    task automatic model_clear;
        mq.delete();
        m_head  = 0;
        m_tail  = 0;
        m_phase = 1'b1;
    endtask

    // one bus cycle: optional push, pop (0x40), IO reset (0x70) or external q_reset
    task automatic cycle_op(input logic push_v, input logic [143:0] d, input logic pop_v,
                            input logic rst_v, input logic qrst_v);
        logic exp_rdy, exp_pop, exp_ack, m_empty, m_full;
        logic [1:0] exp_new;
        idle_inputs();
        cq_wrval  = push_v;
        cq_wrdata = d;
        q_reset   = qrst_v;
        if (pop_v || rst_v) begin
            ctl_cq_iowrite_strobe = 1'b1;
            ctl_cq_iowrite_data   = 36'($urandom);
            ctl_cq_ioaddress      = pop_v ? 32'hC0 : 32'hF0;
        end
        m_empty = (mq.size() == 0);
        m_full  = (mq.size() == NE - 1);
        exp_rdy = !m_full && !rst_v && !qrst_v;
        exp_pop = pop_v && !m_last_pop && !m_empty && !qrst_v;
        exp_ack = (pop_v || rst_v) && !(pop_v && m_last_pop);
        exp_new = exp_pop ? mq[0][65:64] : 2'b00;
        #1;
        chk("wrready", 64'(cq_wrready), 64'(exp_rdy));
        chk("wr_ack", 64'(cq_ctl_ioack), 64'(exp_ack));
        chk("doorbell", 64'(cq_doorbell), 64'(exp_pop));
        chk("sq_update", 64'(sq_head_update), 64'(exp_pop));
        chk("sq_new", 64'(sq_head_new), 64'(exp_new));
        chk("cq_reset", 64'(cq_reset), 64'(rst_v));
        tick();
        if (rst_v || qrst_v) begin
            model_clear();
        end else begin
            if (push_v && exp_rdy) begin
                mq.push_back(d);
                m_tail = (m_tail + 1) % NE;
                if (m_tail == 0) m_phase = ~m_phase;
            end
            if (exp_pop) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % NE;
            end
        end
        m_last_pop = exp_pop;
        chk("head", 64'(cq_head), 64'(m_head));
        chk("tail", 64'(cq_tail), 64'(m_tail));
        idle_inputs();
    endtask

    task automatic io_read(input logic [31:0] addr, input logic [35:0] exp, input string nm);
        idle_inputs();
        ctl_cq_ioaddress     = addr;
        ctl_cq_ioread_strobe = 1'b1;
        tick();
        ctl_cq_ioread_strobe = 1'b0;
        #1;
        chk({nm, "_ack_n1"}, 64'(cq_ctl_ioack), 64'd0);
        tick();
        #1;
        chk({nm, "_ack_n2"}, 64'(cq_ctl_ioack), 64'd1);
        chk({nm, "_data"}, 64'(cq_ctl_ioread_data), 64'(exp));
        tick();
        m_last_pop = 1'b0;
    endtask

    initial begin
        rd_vec_t tbl[8];
        logic [143:0] e0;
        idle_inputs();
        model_clear();
        m_last_pop = 1'b0;

        // reset state and init sequence
        reset_n = 1'b0;
        @(negedge clk);
        tick();
        tick();
        #1;
        chk("rst_rdata", 64'(cq_ctl_ioread_data), 64'({4'hF, 32'h0}));
        chk("rst_ack", 64'(cq_ctl_ioack), 64'd0);
        chk("rst_head", 64'(cq_head), 64'd0);
        chk("rst_tail", 64'(cq_tail), 64'd0);
        chk("rst_wrready", 64'(cq_wrready), 64'd0);
        chk("rst_pulses", 64'({cq_doorbell, sq_head_update, sq_head_new, cq_reset}), 64'd0);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("init_busy", 64'(cq_wrready), 64'd0);
        tick();
        chk("init_done", 64'(cq_wrready), 64'd1);
        io_read(32'hD0, {4'hF, 32'h5}, "st_reset");

        // fill to full, then a held 4th push
        for (int k = 1; k <= 3; k++) cycle_op(1'b1, mk_entry(k), 1'b0, 1'b0, 1'b0);
        cycle_op(1'b1, mk_entry(4), 1'b0, 1'b0, 1'b0);
        cycle_op(1'b1, mk_entry(4), 1'b0, 1'b0, 1'b0);

        // directed reads of the head entry and status
        e0 = mk_entry(1);
        tbl[0] = '{32'h80, {e0[131:128], e0[31:0]},   "dw0"};
        tbl[1] = '{32'h84, {e0[135:132], e0[63:32]},  "dw1"};
        tbl[2] = '{32'h88, {e0[139:136], e0[95:64]},  "dw2"};
        tbl[3] = '{32'h8C, {e0[143:140], e0[127:96]}, "dw3"};
        tbl[4] = '{32'h83, {e0[131:128], e0[31:0]},   "dw0_lowbits"};
        tbl[5] = '{32'hD0, {4'hF, 32'h6},             "st_full"};
        tbl[6] = '{32'hE0, {4'hF, 32'h0},             "other_e0"};
        tbl[7] = '{32'h90, {4'hF, 32'h0},             "other_90"};
        for (int i = 0; i < 8; i++) io_read(tbl[i].addr, tbl[i].exp, tbl[i].nm);

        // pops including back-to-back stalls and a pop on empty
        for (int i = 0; i < 5; i++) cycle_op(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle_op(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle_op(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle_op(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // undecoded pop write and undecoded read: no ack, no effect
        ctl_cq_ioaddress      = 32'h1C0;
        ctl_cq_iowrite_strobe = 1'b1;
        #1;
        chk("undec_wr_ack", 64'(cq_ctl_ioack), 64'd0);
        tick();
        idle_inputs();
        chk("undec_wr_head", 64'(cq_head), 64'(m_head));
        ctl_cq_ioaddress     = 32'h50;
        ctl_cq_ioread_strobe = 1'b1;
        tick();
        idle_inputs();
        tick();
        #1;
        chk("undec_rd_ack", 64'(cq_ctl_ioack), 64'd0);
        tick();

        // push/pop through a tail wrap; phase flips
        for (int i = 0; i < 5; i++) begin
            cycle_op(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0);
            if (i == 0) io_read(32'hD0, status_exp(), "st_wrap");
            cycle_op(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        io_read(32'hD0, status_exp(), "st_after_wrap");
        cycle_op(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // simultaneous push and pop with one entry queued
        cycle_op(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0);
        cycle_op(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle_op(1'b1, rnd_entry(), 1'b1, 1'b0, 1'b0);
        io_read(32'hD0, status_exp(), "st_pushpop");
        io_read(32'h88, dw_exp(mq[0], 2), "dw2_pushpop");

        // IO reset with two queued and a push offered; then external q_reset
        cycle_op(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0);
        cycle_op(1'b1, rnd_entry(), 1'b0, 1'b1, 1'b0);
        io_read(32'hD0, {4'hF, 32'h5}, "st_ioreset");
        cycle_op(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0);
        cycle_op(1'b1, rnd_entry(), 1'b1, 1'b0, 1'b1);
        io_read(32'hD0, status_exp(), "st_qreset");

        // randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                cycle_op(1'b1, rnd_entry(), ($urandom_range(0, 2) == 0), 1'b0, 1'b0);
            end else if (r <= 6) begin
                cycle_op(($urandom_range(0, 3) == 0), rnd_entry(), 1'b1, 1'b0, 1'b0);
            end else if (r == 7) begin
                cycle_op(1'b0, '0, 1'b0, 1'b0, 1'b0);
            end else if (r == 8) begin
                int sel;
                sel = $urandom_range(0, 2);
                if (sel == 0) begin
                    io_read(32'hD0, status_exp(), "rnd_status");
                end else if (sel == 1 && mq.size() != 0) begin
                    int k;
                    k = $urandom_range(0, 3);
                    io_read(32'h80 | (k << 2), dw_exp(mq[0], k), "rnd_dw");
                end else begin
                    int w;
                    w = $urandom_range(4, 31);
                    if (w == 20) w = 21;
                    io_read(32'h80 | (w << 2), {4'hF, 32'h0}, "rnd_other");
                end
            end else begin
                if ($urandom_range(0, 3) == 0)
                    cycle_op(($urandom_range(0, 1) == 1), rnd_entry(), 1'b0, 1'b1, 1'b0);
                else if ($urandom_range(0, 3) == 0)
                    cycle_op(($urandom_range(0, 1) == 1), rnd_entry(), 1'b0, 1'b0, 1'b1);
                else
                    cycle_op(1'b0, '0, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
